bdtackseq: RTL and testbench

BDTACKSEQ -- requirements
Module: bdtackseq

---
 rtl/bdtackseq_if.sv | 40 ++++
 rtl/bdtackseq.sv | 162 ++++++++++++++++
 tb/tb_bdtackseq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bdtackseq_if.sv
// Backplane and address-decoder signals of the DTACK sequencer.
// The slave modport is the sequencer's view of the bus.
interface bdtackseq_if;
  logic       SBSELECT;
  logic       SBREAD_n;
  logic       DTACK_REQ_n;
  logic       ABORT_CLR;
  logic       STROBE_EN;
  logic       RDLATCH;
  logic       DTACK_n;
  logic       BERR_n;
  logic       BUSY;
  logic [7:0] ABORT_CNT;

  modport master (
    output SBSELECT,
    output SBREAD_n,
    output DTACK_REQ_n,
    output ABORT_CLR,
    input  STROBE_EN,
    input  RDLATCH,
    input  DTACK_n,
    input  BERR_n,
    input  BUSY,
    input  ABORT_CNT
  );

  modport slave (
    input  SBSELECT,
    input  SBREAD_n,
    input  DTACK_REQ_n,
    input  ABORT_CLR,
    output STROBE_EN,
    output RDLATCH,
    output DTACK_n,
    output BERR_n,
    output BUSY,
    output ABORT_CNT
  );
endinterface

// File: rtl/bdtackseq.sv
// Backplane slave cycle sequencer: decode, setup, strobe, then DTACK/BERR.
// All outputs are registered from the next-state decode.
module bdtackseq #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 3,
  parameter int TIMEOUT_CYC = 63
) (
  input logic        CCLK,
  input logic        RESET,
  bdtackseq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SETUP,
    STROBE,
    ACK,
    ERR
  } state_t;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYC - 1);
  localparam state_t     AFTER_DEC   =
    (SETUP_CYC == 0) ? STROBE : SETUP;

  state_t     state_q, state_d;
  logic       sync1_q, sel_s_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tmo_q, tmo_d;
  logic       rd_q, rd_d;
  logic       abort;

  logic       strobe_en_q, strobe_en_d;
  logic       rdlatch_q, rdlatch_d;
  logic       dtack_n_q, dtack_n_d;
  logic       berr_n_q, berr_n_d;
  logic       busy_q, busy_d;
  logic [7:0] abort_cnt_q, abort_cnt_d;

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sel_s_q <= 1'b0;
    end else begin
      sync1_q <= bus.SBSELECT;
      sel_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rd_d    = rd_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_s_q) begin
          state_d = DECODE;
          tmo_d   = '0;
        end
      end
      DECODE: begin
        if (!sel_s_q) begin
          state_d = IDLE;
        end else if (!bus.DTACK_REQ_n) begin
          state_d = AFTER_DEC;
          rd_d    = ~bus.SBREAD_n;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      SETUP: begin
        if (!sel_s_q) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        if (!sel_s_q) begin
          state_d = IDLE;
          abort   = 1'b1;
        end else if (cnt_q == STROBE_LAST) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ACK: begin
        if (!sel_s_q) state_d = IDLE;
      end
      ERR: begin
        if (!sel_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a same-edge abort; count sticks at 255.
  always_comb begin
    abort_cnt_d = abort_cnt_q;
    if (bus.ABORT_CLR) begin
      abort_cnt_d = '0;
    end else if (abort && abort_cnt_q != 8'hff) begin
      abort_cnt_d = abort_cnt_q + 8'd1;
    end
  end

  always_comb begin
    strobe_en_d = (state_d == STROBE);
    rdlatch_d   = (state_d == STROBE) &&
                  (cnt_d == STROBE_LAST) && rd_d;
    dtack_n_d   = (state_d != ACK);
    berr_n_d    = (state_d != ERR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge CCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      rd_q        <= 1'b0;
      strobe_en_q <= 1'b0;
      rdlatch_q   <= 1'b0;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      rd_q        <= rd_d;
      strobe_en_q <= strobe_en_d;
      rdlatch_q   <= rdlatch_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
      busy_q      <= busy_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign bus.STROBE_EN = strobe_en_q;
  assign bus.RDLATCH   = rdlatch_q;
  assign bus.DTACK_n   = dtack_n_q;
  assign bus.BERR_n    = berr_n_q;
  assign bus.BUSY      = busy_q;
  assign bus.ABORT_CNT = abort_cnt_q;

endmodule

// File: tb/tb_bdtackseq.sv
// Bench for bdtackseq: output edges are scoreboarded against
// hand-computed edge numbers; static values are checked directly.
module tb_bdtackseq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    int id;
    int kind;
    int edge_n;
  } ev_t;

  ev_t        exp_q[$];
  logic [3:0] pv[2];

  bdtackseq_if ba();
  bdtackseq_if bb();

  bdtackseq dut_a (
    .CCLK  (clk),
    .RESET (rst),
    .bus   (ba)
  );

  bdtackseq #(
    .SETUP_CYC   (0),
    .STROBE_CYC  (1),
    .TIMEOUT_CYC (4)
  ) dut_b (
    .CCLK  (clk),
    .RESET (rst),
    .bus   (bb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 0 SE rise, 1 SE fall, 2 RDLATCH high,
  // 3 DTACK fall, 4 DTACK rise, 5 BERR fall, 6 BERR rise
  task automatic exp(input int id, input int kind, input int e);
    ev_t v;
    v.id = id;
    v.kind = kind;
    v.edge_n = e;
    exp_q.push_back(v);
  endtask

  task automatic see(input int id, input int kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got dut%0d kind %0d edge %0d, required none",
               id, kind, cyc - 1);
    end else begin
      e = exp_q.pop_front();
      if (e.id != id || e.kind != kind || e.edge_n != cyc - 1) begin
        n_bad++;
        $display("FAIL event: got dut%0d kind %0d edge %0d, required dut%0d kind %0d edge %0d",
                 id, kind, cyc - 1, e.id, e.kind, e.edge_n);
      end
    end
  endtask

  task automatic scan(input int id, input logic [3:0] cur);
    if (cur[3] && !pv[id][3]) see(id, 0);
    if (!cur[3] && pv[id][3]) see(id, 1);
    if (cur[2]) see(id, 2);
    if (!cur[1] && pv[id][1]) see(id, 3);
    if (cur[1] && !pv[id][1]) see(id, 4);
    if (!cur[0] && pv[id][0]) see(id, 5);
    if (cur[0] && !pv[id][0]) see(id, 6);
    pv[id] = cur;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic drive(input int id, input logic sel, input logic rdn,
                       input logic req, input logic clr);
    if (id == 0) begin
      ba.SBSELECT = sel;
      ba.SBREAD_n = rdn;
      ba.DTACK_REQ_n = req;
      ba.ABORT_CLR = clr;
    end else begin
      bb.SBSELECT = sel;
      bb.SBREAD_n = rdn;
      bb.DTACK_REQ_n = req;
      bb.ABORT_CLR = clr;
    end
  endtask

  task automatic at_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic xfer(input int id, input logic rdn,
                      input int su, input int st);
    int e0;
    int m;
    @(negedge clk);
    e0 = cyc;
    drive(id, 1'b1, rdn, 1'b0, 1'b0);
    exp(id, 0, e0 + 3 + su);
    if (!rdn) exp(id, 2, e0 + 2 + su + st);
    exp(id, 1, e0 + 3 + su + st);
    exp(id, 3, e0 + 3 + su + st);
    at_edge(e0 + 6 + su + st);
    m = cyc;
    drive(id, 1'b0, 1'b1, 1'b1, 1'b0);
    exp(id, 4, m + 2);
    at_edge(m + 5);
  endtask

  task automatic tmo(input int id, input int t);
    int e0;
    int m;
    @(negedge clk);
    e0 = cyc;
    drive(id, 1'b1, 1'b1, 1'b1, 1'b0);
    exp(id, 5, e0 + 2 + t);
    at_edge(e0 + 5 + t);
    m = cyc;
    drive(id, 1'b0, 1'b1, 1'b1, 1'b0);
    exp(id, 6, m + 2);
    at_edge(m + 5);
  endtask

  task automatic abort_a(input logic clr);
    int e0;
    @(negedge clk);
    e0 = cyc;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp(0, 0, e0 + 4);
    exp(0, 1, e0 + 6);
    at_edge(e0 + 4);
    drive(0, 1'b0, 1'b1, 1'b0, 1'b0);
    at_edge(e0 + 6);
    ba.ABORT_CLR = clr;
    at_edge(e0 + 7);
    ba.ABORT_CLR = 1'b0;
    at_edge(e0 + 9);
  endtask

  task automatic stim();
    int e0;
    xfer(0, 1'b1, 1, 3);
    xfer(0, 1'b0, 1, 3);
    tmo(0, 63);
    chk("dtack_after_berr", 32'(ba.DTACK_n), 1);

    abort_a(1'b0);
    chk("abort_cnt_1", 32'(ba.ABORT_CNT), 1);
    @(negedge clk);
    e0 = cyc;
    drive(0, 1'b1, 1'b1, 1'b1, 1'b0);
    at_edge(e0 + 1);
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    at_edge(e0 + 6);
    chk("decode_abort_cnt", 32'(ba.ABORT_CNT), 1);
    chk("decode_abort_busy", 32'(ba.BUSY), 0);

    for (int i = 0; i < 254; i++) abort_a(1'b0);
    chk("abort_cnt_255", 32'(ba.ABORT_CNT), 255);
    abort_a(1'b0);
    chk("abort_cnt_sat", 32'(ba.ABORT_CNT), 255);
    abort_a(1'b1);
    chk("abort_clr", 32'(ba.ABORT_CNT), 0);
    abort_a(1'b0);
    chk("abort_after_clr", 32'(ba.ABORT_CNT), 1);

    @(negedge clk);
    e0 = cyc;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    exp(0, 0, e0 + 4);
    exp(0, 1, e0 + 7);
    exp(0, 3, e0 + 7);
    at_edge(e0 + 9);
    #2;
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp(0, 4, cyc);
    #1;
    chk("async_dtack", 32'(ba.DTACK_n), 1);
    chk("async_busy", 32'(ba.BUSY), 0);
    chk("async_berr", 32'(ba.BERR_n), 1);
    chk("async_cnt", 32'(ba.ABORT_CNT), 0);
    at_edge(e0 + 12);
    rst = 1'b0;
    at_edge(e0 + 18);
    chk("post_reset_busy", 32'(ba.BUSY), 0);

    xfer(1, 1'b1, 0, 1);
    xfer(1, 1'b0, 0, 1);
    tmo(1, 4);
  endtask

  initial begin
    drive(0, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1, 1'b0, 1'b1, 1'b1, 1'b0);
    pv[0] = 4'b0011;
    pv[1] = 4'b0011;
    #1 rst = 1'b1;
    #1;
    chk("rst_strobe_en", 32'(ba.STROBE_EN), 0);
    chk("rst_rdlatch", 32'(ba.RDLATCH), 0);
    chk("rst_dtack", 32'(ba.DTACK_n), 1);
    chk("rst_berr", 32'(ba.BERR_n), 1);
    chk("rst_busy", 32'(ba.BUSY), 0);
    chk("rst_cnt", 32'(ba.ABORT_CNT), 0);
    chk("rst_b_dtack", 32'(bb.DTACK_n), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        scan(0, {ba.STROBE_EN, ba.RDLATCH, ba.DTACK_n, ba.BERR_n});
        scan(1, {bb.STROBE_EN, bb.RDLATCH, bb.DTACK_n, bb.BERR_n});
      end
      stim();
    join_any
    chk("events_left", 32'(exp_q.size()), 0);
    chk("end_busy_b", 32'(bb.BUSY), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
